// File: rtl/patch_row_dispatcher_if.sv
// patch_row_dispatcher_if: config, reducer-bank and result signals of patch_row_dispatcher
// master: config source, reducer bank and result sink (drives cfg_valid/cfg_data, sum_rdy/sums, out_ready)
// slave : dispatcher (drives cfg_ready, init/config_data, sum_ack, out_valid/out_idx/out_sum, busy, protocol_err)
interface patch_row_dispatcher_if #(
    parameter int APP_DATA_WIDTH = 256,
    parameter int N_ROW_REDUCER  = 4,
    parameter int ROW_SUM_SIZE   = 32,
    parameter int IDX_W          = (N_ROW_REDUCER > 1) ? $clog2(N_ROW_REDUCER) : 1
);
    logic                                    cfg_valid;
    logic [APP_DATA_WIDTH-1:0]               cfg_data;
    logic                                    cfg_ready;
    logic [N_ROW_REDUCER-1:0]                init;
    logic [APP_DATA_WIDTH-1:0]               config_data;
    logic [N_ROW_REDUCER-1:0]                sum_rdy;
    logic [N_ROW_REDUCER*ROW_SUM_SIZE-1:0]   sums;
    logic [N_ROW_REDUCER-1:0]                sum_ack;
    logic                                    out_valid;
    logic                                    out_ready;
    logic [IDX_W-1:0]                        out_idx;
    logic [ROW_SUM_SIZE-1:0]                 out_sum;
    logic [N_ROW_REDUCER-1:0]                busy;
    logic                                    protocol_err;
    modport master (
        output cfg_valid, cfg_data, sum_rdy, sums, out_ready,
        input  cfg_ready, init, config_data, sum_ack, out_valid, out_idx, out_sum, busy, protocol_err
    );
    modport slave (
        input  cfg_valid, cfg_data, sum_rdy, sums, out_ready,
        output cfg_ready, init, config_data, sum_ack, out_valid, out_idx, out_sum, busy, protocol_err
    );
endinterface

// File: rtl/patch_row_dispatcher.sv
// patch_row_dispatcher: dispatches config words to idle row reducers and streams their sums downstream
// dram_clk : single clock
// reset_n  : synchronous active-low reset
// bus      : slave side of patch_row_dispatcher_if (config in, init/ack to reducers, result out, status)
module patch_row_dispatcher #(
    parameter int APP_DATA_WIDTH = 256,
    parameter int N_ROW_REDUCER  = 4,
    parameter int ROW_SUM_SIZE   = 32,
    parameter int IDX_W          = (N_ROW_REDUCER > 1) ? $clog2(N_ROW_REDUCER) : 1
) (
    input logic                 dram_clk,
    input logic                 reset_n,
    patch_row_dispatcher_if.slave bus
);
    typedef enum logic {C_IDLE, C_ACK} c_state_t;
    c_state_t                  state_q, state_d;
    logic                      en_q;
    logic [N_ROW_REDUCER-1:0]  busy_q, busy_d, init_q, init_d, ack_q, ack_d;
    logic [APP_DATA_WIDTH-1:0] cfg_q, cfg_d;
    logic                      out_valid_q, out_valid_d, perr_q, perr_d;
    logic [IDX_W-1:0]          out_idx_q, out_idx_d, ptr_q, ptr_d;
    logic [ROW_SUM_SIZE-1:0]   out_sum_q, out_sum_d;
    logic                      cfg_ready, accept, found, grant;
    logic [N_ROW_REDUCER-1:0]  cand;
    logic [IDX_W-1:0]          k, g, idx;
    // en_q holds cfg_ready low during the reset cycle and rises one cycle after release
    assign cfg_ready = en_q && (busy_q != '1) && !(|init_q);
    assign accept    = bus.cfg_valid && cfg_ready;
    assign cand      = bus.sum_rdy & busy_q;
    always_comb begin
        k     = '0;
        g     = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = N_ROW_REDUCER - 1; i >= 0; i--)
            if (!busy_q[i]) k = IDX_W'(i);
        // round-robin scan starting at the pointer, wrapping past the last reducer
        for (int i = 0; i < N_ROW_REDUCER; i++) begin
            idx = IDX_W'((int'(ptr_q) + i) % N_ROW_REDUCER);
            if (!found && cand[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        grant = (state_q == C_IDLE) && (!out_valid_q || bus.out_ready) && found;
    end
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        init_d      = '0;
        ack_d       = '0;
        cfg_d       = cfg_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_idx_d   = out_idx_q;
        out_sum_d   = out_sum_q;
        ptr_d       = ptr_q;
        perr_d      = perr_q || |(bus.sum_rdy & ~busy_q & ~ack_q & ~init_q);
        if (accept) begin
            init_d[k] = 1'b1;
            busy_d[k] = 1'b1;
            cfg_d     = bus.cfg_data;
        end
        // the acked reducer's sum_rdy is still stale in C_ACK, so no grant here
        if (state_q == C_ACK) begin
            busy_d  = busy_d & ~ack_q;
            state_d = C_IDLE;
        end else if (grant) begin
            ack_d[g]    = 1'b1;
            out_valid_d = 1'b1;
            out_idx_d   = g;
            out_sum_d   = bus.sums[int'(g)*ROW_SUM_SIZE +: ROW_SUM_SIZE];
            ptr_d       = (int'(g) == N_ROW_REDUCER - 1) ? '0 : g + 1'b1;
            state_d     = C_ACK;
        end
    end
    always_ff @(posedge dram_clk) begin
        if (!reset_n) begin
            state_q     <= C_IDLE;
            en_q        <= 1'b0;
            busy_q      <= '0;
            init_q      <= '0;
            ack_q       <= '0;
            cfg_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_sum_q   <= '0;
            ptr_q       <= '0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= 1'b1;
            busy_q      <= busy_d;
            init_q      <= init_d;
            ack_q       <= ack_d;
            cfg_q       <= cfg_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_sum_q   <= out_sum_d;
            ptr_q       <= ptr_d;
            perr_q      <= perr_d;
        end
    end
    assign bus.cfg_ready    = cfg_ready;
    assign bus.init         = init_q;
    assign bus.config_data  = cfg_q;
    assign bus.sum_ack      = ack_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_idx      = out_idx_q;
    assign bus.out_sum      = out_sum_q;
    assign bus.busy         = busy_q;
    assign bus.protocol_err = perr_q;
endmodule

// File: tb/tb_patch_row_dispatcher.sv
// tb_patch_row_dispatcher: directed scoreboard bench for patch_row_dispatcher
module tb_patch_row_dispatcher;
    logic dram_clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    logic [3:0]   exp_init[$];
    logic [33:0]  exp_out[$];
    logic [255:0] cfg_q[$];
    patch_row_dispatcher_if #(.APP_DATA_WIDTH(256), .N_ROW_REDUCER(4), .ROW_SUM_SIZE(32)) bus ();
    patch_row_dispatcher #(.APP_DATA_WIDTH(256), .N_ROW_REDUCER(4), .ROW_SUM_SIZE(32)) dut (
        .dram_clk (dram_clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );
    initial dram_clk = 1'b0;
    always #5 dram_clk = ~dram_clk;
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [255:0] w);
        cfg_q.push_back(w);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = cfg_q[0];
    endtask
    // scoreboard compares before the edge, then one clock; the reducer model drops sum_rdy after an ack
    task automatic step();
        logic [3:0] ack_s;
        logic       acc;
        if (bus.init != 4'b0) begin
            chk("init_expected", exp_init.size() != 0, 1);
            if (exp_init.size() != 0) chk("init", bus.init, exp_init.pop_front());
        end
        if (bus.out_valid && bus.out_ready) begin
            chk("out_expected", exp_out.size() != 0, 1);
            if (exp_out.size() != 0) chk("out_idx_sum", {bus.out_idx, bus.out_sum}, exp_out.pop_front());
        end
        ack_s = bus.sum_ack;
        acc   = bus.cfg_valid && bus.cfg_ready;
        @(posedge dram_clk);
        #1;
        bus.sum_rdy = bus.sum_rdy & ~ack_s;
        if (acc) void'(cfg_q.pop_front());
        bus.cfg_valid = cfg_q.size() != 0;
        if (cfg_q.size() != 0) bus.cfg_data = cfg_q[0];
    endtask
    initial begin
        reset_n       = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        bus.sum_rdy   = '0;
        bus.sums      = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_cfg_ready", bus.cfg_ready, 0);
        chk("rst_init", bus.init, 0);
        chk("rst_config_data", bus.config_data, 0);
        chk("rst_sum_ack", bus.sum_ack, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_idx", bus.out_idx, 0);
        chk("rst_out_sum", bus.out_sum, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_perr", bus.protocol_err, 0);
        reset_n = 1'b1;
        step();
        chk("cfg_ready_after_rst", bus.cfg_ready, 1);
        // first dispatch
        send({8{32'hA5A5A5A5}});
        exp_init.push_back(4'b0001);
        step();
        chk("t1_init", bus.init, 4'b0001);
        chk("t1_config_data", bus.config_data, {8{32'hA5A5A5A5}});
        chk("t1_busy", bus.busy, 4'b0001);
        chk("t1_cfg_ready_low", bus.cfg_ready, 0);
        step();
        chk("t1_init_done", bus.init, 0);
        chk("t1_cfg_ready_back", bus.cfg_ready, 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk("t1_busy_cleared", bus.busy, 0);
        // five configs back to back, only four reducers
        for (int i = 1; i <= 5; i++) send(256'(i));
        exp_init.push_back(4'b0001);
        exp_init.push_back(4'b0010);
        exp_init.push_back(4'b0100);
        exp_init.push_back(4'b1000);
        repeat (12) step();
        chk("t2_busy_full", bus.busy, 4'b1111);
        chk("t2_cfg_ready_low", bus.cfg_ready, 0);
        chk("t2_inits_seen", exp_init.size(), 0);
        // all reducers finish; the held fifth word goes to the first freed reducer (0)
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.sums[i*32 +: 32] = 32'(100 + i);
            exp_out.push_back({2'(i), 32'(100 + i)});
        end
        exp_init.push_back(4'b0001);
        bus.sum_rdy = 4'b1111;
        repeat (10) step();
        chk("t3_outs_seen", exp_out.size(), 0);
        chk("t3_fifth_dispatched", exp_init.size(), 0);
        chk("t3_busy_fifth", bus.busy, 4'b0001);
        bus.sums[31:0] = 32'd300;
        exp_out.push_back({2'd0, 32'd300});
        bus.sum_rdy = 4'b0001;
        repeat (4) step();
        chk("t3_busy_empty", bus.busy, 0);
        // output stall holds the result and blocks further acks
        send(256'h11);
        send(256'h22);
        send(256'h33);
        exp_init.push_back(4'b0001);
        exp_init.push_back(4'b0010);
        exp_init.push_back(4'b0100);
        repeat (7) step();
        chk("t4_busy", bus.busy, 4'b0111);
        bus.out_ready = 1'b0;
        bus.sums[64 +: 32] = 32'h1234;
        bus.sum_rdy = 4'b0100;
        exp_out.push_back({2'd2, 32'h1234});
        step();
        chk("t4_out_valid", bus.out_valid, 1);
        chk("t4_out_idx", bus.out_idx, 2);
        chk("t4_out_sum", bus.out_sum, 32'h1234);
        chk("t4_ack", bus.sum_ack, 4'b0100);
        bus.sums[31:0] = 32'd55;
        bus.sum_rdy = bus.sum_rdy | 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_no_ack_stalled", bus.sum_ack, 0);
            chk("t4_sum_held", {bus.out_valid, bus.out_sum}, {1'b1, 32'h1234});
        end
        exp_out.push_back({2'd0, 32'd55});
        bus.out_ready = 1'b1;
        step();
        chk("t4_b2b_idx", bus.out_idx, 0);
        repeat (3) step();
        chk("t4_outs_seen", exp_out.size(), 0);
        chk("t4_busy_left", bus.busy, 4'b0010);
        // round robin: free reducer 1 to move the pointer to 2, then refill 0 and 1
        bus.sums[32 +: 32] = 32'd77;
        bus.sum_rdy = 4'b0010;
        exp_out.push_back({2'd1, 32'd77});
        repeat (4) step();
        chk("t5_busy_empty", bus.busy, 0);
        send(256'h44);
        send(256'h55);
        exp_init.push_back(4'b0001);
        exp_init.push_back(4'b0010);
        repeat (5) step();
        chk("t5_busy", bus.busy, 4'b0011);
        bus.sums[31:0]   = 32'd200;
        bus.sums[32 +: 32] = 32'd201;
        bus.sums[96 +: 32] = 32'hDEAD;
        exp_out.push_back({2'd0, 32'd200});
        exp_out.push_back({2'd1, 32'd201});
        bus.sum_rdy = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5_no_ack3", bus.sum_ack[3], 0);
        end
        chk("t5_perr", bus.protocol_err, 1);
        chk("t5_busy_done", bus.busy, 0);
        chk("t5_outs_seen", exp_out.size(), 0);
        // reset in C_ACK with a pending output
        bus.sum_rdy = 4'b0000;
        send(256'h66);
        exp_init.push_back(4'b0001);
        repeat (3) step();
        bus.out_ready = 1'b0;
        bus.sums[31:0] = 32'd9;
        bus.sum_rdy = 4'b0001;
        step();
        chk("t6_out_valid", bus.out_valid, 1);
        chk("t6_ack", bus.sum_ack, 4'b0001);
        reset_n = 1'b0;
        bus.sum_rdy = 4'b0000;
        step();
        chk("t6_rst_outs", {bus.cfg_ready, bus.init, bus.sum_ack, bus.out_valid, bus.out_idx, bus.busy, bus.protocol_err}, 0);
        chk("t6_rst_sum", bus.out_sum, 0);
        chk("t6_rst_cfg", bus.config_data, 0);
        reset_n = 1'b1;
        step();
        chk("t6_cfg_ready", bus.cfg_ready, 1);
        chk("t6_busy", bus.busy, 0);
        chk("end_inits_seen", exp_init.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
